// File: rtl/univ_shiftreg_pkg.sv
// Shared encodings and helpers for the universal shift register.
// Mode and FSM encodings live here so the datapath and the control agree on them.
package univ_shiftreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter must be able to hold the value WIDTH itself, hence the +1.
    function automatic int cntw(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic is_multistep(input logic [2:0] m);
        case (m)
            MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/univ_shiftreg_step.sv
// One-step next-value logic, shared by single-cycle operation and multi-step runs.
module univ_shiftreg_step
    import univ_shiftreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] parallelin,
    input  logic             serialinr,
    input  logic             serialinl,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_HOLD: nxt = cur;
            MODE_SHR:  nxt = {serialinr, cur[WIDTH-1:1]};
            MODE_SHL:  nxt = {cur[WIDTH-2:0], serialinl};
            MODE_LOAD: nxt = parallelin;
            MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLR:  nxt = '0;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/univ_shiftreg.sv
// Universal shift register with single-cycle modes and a counted multi-step run.
// Handshake: start is sampled only in IDLE with enable=1; busy marks RUN, done pulses once after the last step.
module univ_shiftreg
    import univ_shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = cntw(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNTW-1:0]  shamt,
    input  logic             serialinr,
    input  logic             serialinl,
    input  logic [WIDTH-1:0] parallelin,
    output logic [WIDTH-1:0] parallelout,
    output logic             serialoutr,
    output logic             serialoutl,
    output logic             busy,
    output logic             done
);

    state_e           state;
    state_e           state_next;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_next;
    logic [2:0]       run_mode;
    logic [2:0]       run_mode_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] step_value;
    logic             done_q;
    logic             done_next;
    logic [2:0]       step_mode;
    logic [CNTW-1:0]  shamt_clamped;
    logic             start_multi;

    // During RUN the latched mode drives the step logic; live mode is ignored.
    assign step_mode     = (state == ST_RUN) ? run_mode : mode;
    assign shamt_clamped = (shamt > CNTW'(WIDTH)) ? CNTW'(WIDTH) : shamt;
    assign start_multi   = start && is_multistep(mode);

    univ_shiftreg_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode       (step_mode),
        .cur        (shreg),
        .parallelin (parallelin),
        .serialinr  (serialinr),
        .serialinl  (serialinl),
        .nxt        (step_value)
    );

    always_comb begin
        state_next    = state;
        count_next    = count;
        run_mode_next = run_mode;
        shreg_next    = shreg;
        done_next     = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (start_multi) begin
                        run_mode_next = mode;
                        count_next    = shamt_clamped;
                        if (shamt_clamped == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end else begin
                        shreg_next = step_value;
                    end
                end
                ST_RUN: begin
                    shreg_next = step_value;
                    count_next = count - CNTW'(1);
                    if (count == CNTW'(1)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            run_mode <= MODE_HOLD;
            shreg    <= '0;
            done_q   <= 1'b0;
        end else begin
            count    <= count_next;
            run_mode <= run_mode_next;
            shreg    <= shreg_next;
            done_q   <= done_next;
        end
    end

    assign parallelout = shreg;
    assign serialoutr  = shreg[0];
    assign serialoutl  = shreg[WIDTH-1];
    assign busy        = (state == ST_RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_univ_shiftreg.sv
// Self-checking bench for univ_shiftreg (WIDTH=8): directed scenarios plus random single-cycle ops.
module tb_univ_shiftreg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [2:0]    mode;
    logic          start;
    logic [CW-1:0] shamt;
    logic          serialinr;
    logic          serialinl;
    logic [W-1:0]  parallelin;
    logic [W-1:0]  parallelout;
    logic          serialoutr;
    logic          serialoutl;
    logic          busy;
    logic          done;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model;

    always #5 clock = ~clock;

    univ_shiftreg #(
        .WIDTH(W),
        .CNTW (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .mode        (mode),
        .start       (start),
        .shamt       (shamt),
        .serialinr   (serialinr),
        .serialinl   (serialinl),
        .parallelin  (parallelin),
        .parallelout (parallelout),
        .serialoutr  (serialoutr),
        .serialoutl  (serialoutl),
        .busy        (busy),
        .done        (done)
    );

    // Bit-level reference model, written per output bit rather than as slices.
    function automatic logic [W-1:0] model_step(input logic [2:0] m, input logic [W-1:0] cur,
                                                input logic [W-1:0] pin, input logic sr,
                                                input logic sl);
        logic [W-1:0] n;
        n = cur;
        if (m == 3'd3) return pin;
        if (m == 3'd7) return '0;
        for (int i = 0; i < W; i++) begin
            case (m)
                3'd1: n[i] = (i == W - 1) ? sr : cur[(i + 1) % W];
                3'd2: n[i] = (i == 0) ? sl : cur[(i + W - 1) % W];
                3'd4: n[i] = cur[(i + 1) % W];
                3'd5: n[i] = cur[(i + W - 1) % W];
                3'd6: n[i] = (i == W - 1) ? cur[W-1] : cur[(i + 1) % W];
                default: n[i] = cur[i];
            endcase
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        check_val({tag, "_qdepth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(tag, 32'(parallelout), 32'(e));
            check_val({tag, "_sor"}, 32'(serialoutr), 32'(e[0]));
            check_val({tag, "_sol"}, 32'(serialoutl), 32'(e[W-1]));
        end
    endtask

    task automatic single_op(input logic [2:0] m, input logic [W-1:0] pin, input logic sr,
                             input logic sl, input logic st, input logic en, input string tag);
        mode       = m;
        parallelin = pin;
        serialinr  = sr;
        serialinl  = sl;
        start      = st;
        enable     = en;
        if (en) model = model_step(m, model, pin, sr, sl);
        exp_q.push_back(model);
        edge_tick();
        check_out(tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        start  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic multi_run(input logic [2:0] m, input logic [CW-1:0] amt, input logic sr,
                             input logic sl, input int stall_at, input int stall_len,
                             input logic [W-1:0] exp_final, input int exp_busy,
                             input string tag);
        int busy_cnt;
        mode      = m;
        shamt     = amt;
        serialinr = sr;
        serialinl = sl;
        start     = 1'b1;
        enable    = 1'b1;
        exp_q.push_back(exp_final);
        edge_tick();
        check_val({tag, "_start_hold"}, 32'(parallelout), 32'(model));
        // Junk on the control inputs during RUN must have no effect.
        mode       = 3'b011;
        start      = 1'b1;
        parallelin = W'($urandom_range(0, 255));
        shamt      = CW'($urandom_range(0, 15));
        busy_cnt   = 0;
        for (int i = 0; i < 64; i++) begin
            if (done) break;
            if (busy) busy_cnt++;
            enable = !(i >= stall_at && i < stall_at + stall_len);
            edge_tick();
        end
        enable = 1'b1;
        start  = 1'b0;
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_out(tag);
        model = exp_final;
        mode  = 3'b000;
        edge_tick();
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_after_hold"}, 32'(parallelout), 32'(model));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] m;
        logic       st;
        logic       en;

        // Clock/reset
        reset_n    = 1'b0;
        enable     = 1'b1;
        mode       = 3'b000;
        start      = 1'b0;
        shamt      = '0;
        serialinr  = 1'b0;
        serialinl  = 1'b0;
        parallelin = '0;
        model      = '0;
        #12;
        check_val("reset_value", 32'(parallelout), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Load and serial outputs, then hold
        single_op(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "load_a5");
        for (int i = 0; i < 3; i++) single_op(3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, "hold_a5");

        // Multi-step shift right with fill 1
        multi_run(3'b001, 4'd3, 1'b1, 1'b0, -1, 0, 8'hF4, 3, "shr3");

        // Arithmetic shift with two stall cycles
        single_op(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, "load_81");
        multi_run(3'b110, 4'd2, 1'b0, 1'b0, 1, 2, 8'hE0, 4, "asr2_stall");

        // Clamp of an oversize count
        single_op(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "load_a5b");
        multi_run(3'b101, 4'd12, 1'b0, 1'b0, -1, 0, 8'hA5, 8, "rol12_clamp");

        // Zero count
        multi_run(3'b100, 4'd0, 1'b0, 1'b0, -1, 0, 8'hA5, 0, "ror0");

        // Random single-cycle ops, including ignored starts and idle stalls
        for (int i = 0; i < 40; i++) begin
            m  = 3'($urandom_range(0, 7));
            st = (m == 3'b000 || m == 3'b011 || m == 3'b111) ? 1'($urandom_range(0, 1)) : 1'b0;
            en = ($urandom_range(0, 4) != 0);
            shamt = CW'($urandom_range(1, 15));
            single_op(m, W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), st, en, "rand_op");
        end

        // Reset in the middle of a run
        single_op(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, "load_a5c");
        mode  = 3'b100;
        shamt = 4'd5;
        start = 1'b1;
        edge_tick();
        start = 1'b0;
        exp_q.push_back(8'h69);
        edge_tick();
        edge_tick();
        check_out("ror_two_steps");
        check_val("ror_busy_mid", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrun_reset_value", 32'(parallelout), 32'd0);
        check_val("midrun_reset_busy", 32'(busy), 32'd0);
        check_val("midrun_reset_done", 32'(done), 32'd0);
        edge_tick();
        check_val("reset_held_busy", 32'(busy), 32'd0);
        #3;
        reset_n = 1'b1;
        model   = '0;
        single_op(3'b011, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset_load");
        single_op(3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "post_reset_shl");

        // Final report
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg.md
UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 Parameter CNTW SHALL be: CNTW, default $clog2(WIDTH)+1, width of the shift-amount and step counter.
REQ-003 Port clock SHALL be: clock  input  1  single clock, rising-edge active.
REQ-004 Port reset_n SHALL be: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port enable SHALL be: enable  input  1  clock qualifier; low = no state change (stall).
REQ-006 Port mode SHALL be: mode  input  3  operation select (encodings per REQ-012).
REQ-007 Port start SHALL be: start  input  1  begin a multi-step shift/rotate of shamt steps.
REQ-008 Port shamt SHALL be: shamt  input  CNTW  step count for start.
REQ-009 Port serialinr and serialinl SHALL be: serialinr/serialinl  input  1 each  fill bit for right/left shift.
REQ-010 Port parallelin SHALL be: parallelin  input  WIDTH  parallel load data.
REQ-011 Outputs SHALL be: parallelout  output  WIDTH  register contents; serialoutr  output  1  reg[0]; serialoutl  output  1  reg[WIDTH-1]; busy  output  1  multi-step in progress; done  output  1  one-cycle completion pulse.

Function
REQ-012 Modes SHALL be: 000 hold; 001 shift right (serialinr -> MSB); 010 shift left (serialinl -> LSB); 011 parallel load; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 clear to 0.
REQ-013 In IDLE, with enable=1 and start=0, the register SHALL update by the selected mode once per rising edge.
REQ-014 In IDLE, with enable=1, start=1, and mode in {001,010,100,101,110}, the block SHALL latch mode and count=min(shamt,WIDTH), make no register change on that edge, and enter RUN if count>0.
REQ-015 In RUN, the block SHALL perform one step of the latched mode per edge with enable=1, decrement count, and freeze (stall) on edges with enable=0.
REQ-016 In RUN, the block SHALL ignore mode, start, shamt and parallelin; serial inputs SHALL be sampled live on every step.
REQ-017 busy SHALL be high exactly while in RUN; N enabled steps SHALL give N busy cycles when there are no stalls.
REQ-018 done SHALL pulse high for one cycle after the edge performing the final step; for start with shamt=0, done SHALL pulse after the start edge, and busy SHALL stay low.
REQ-019 start with mode in {000,011,111} SHALL be treated as start=0 (single-cycle operation), and no done SHALL be produced.
REQ-020 serialoutr and serialoutl SHALL be combinational from the register, never from separate latches.
REQ-021 There SHALL be no X-detection on serial inputs; the value is used as sampled.

Reset
REQ-022 Asserting reset_n low SHALL immediately (asynchronously) force register=0, state=IDLE, count=0, busy=0 and done=0, including mid-RUN.
REQ-023 After reset deassertion, the first enabled edge SHALL be treated as IDLE.

Structure
REQ-024 Mode encodings, the IDLE/RUN state encoding, and the CNTW function SHALL reside in the shared package univ_shiftreg_pkg.
REQ-025 The one-step next-value logic SHALL be the combinational sub-module univ_shiftreg_step (mode, reg, serial inputs -> next reg), reused for both IDLE and RUN.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover load and serial outputs: mode=011, parallelin=0xA5, one edge -> parallelout=0xA5, serialoutr=1, serialoutl=1; then mode=000 for 3 edges -> value held at 0xA5.
REQ-027 The bench SHALL cover a multi-step shift: from 0xA5, start mode=001, shamt=3, serialinr=1 -> busy for 3 cycles, parallelout=0xF4, done pulse on the 4th cycle.
REQ-028 The bench SHALL cover clamp and stall: from 0x81, start mode=110, shamt=2, enable=0 for 2 cycles mid-run -> parallelout=0xE0, busy for 4 cycles; from 0xA5, rotate left with shamt=12 -> 8 steps, result 0xA5.
REQ-029 The bench SHALL cover a zero count: start mode=100, shamt=0 -> value unchanged, busy never high, done one cycle.
REQ-030 The bench SHALL cover reset mid-run: start mode=100, shamt=5 from 0xA5, pull reset_n low after 2 steps -> parallelout=0, busy=0, done=0 immediately; normal IDLE operation resumes after release.
